// File: rtl/fib_timer_ctrl.sv
// Mode controller for the Fibonacci/timer datapaths: run sequencing, prescaler, LEDs.
// Optional CTRL_AUTORETURN_EN: DONE returns to IDLE after HOLD_TICKS prescaler wraps.
module fib_timer_ctrl #(
    parameter int DIV        = 4,
    parameter int HOLD_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_f,
    input  logic       start_t,
    input  logic       stop_f_t,
    input  logic       update,
    input  logic [2:0] prog,
    input  logic       f_done,
    input  logic       t_done,
    output logic [2:0] prog_q,
    output logic       en_f,
    output logic       en_t,
    output logic       tick,
    output logic       clr,
    output logic       sel,
    output logic [5:0] led,
    output logic       parity
);

    typedef enum logic [1:0] {IDLE, FIB, TIMER, DONE} state_t;

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    prog_d;
    logic          sel_q, sel_d;
    logic          clr_q, clr_d;
    logic          tick_q, tick_d;
    logic          start_ok;
    logic          run;
    logic          wrap;
    logic          cnt_en;
    logic          expire;

    assign run  = (state_q == FIB) || (state_q == TIMER);
    assign wrap = (cnt_q == CNT_MAX);

`ifdef CTRL_AUTORETURN_EN
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    logic [HW-1:0] hold_q, hold_d;

    // Prescaler stays alive in DONE so it can time the hold period.
    assign cnt_en = run || (state_q == DONE);
    assign expire = (state_q == DONE) && wrap
                    && (hold_q == HW'(HOLD_TICKS - 1));

    always_comb begin
        hold_d = '0;
        if ((state_q == DONE) && (state_d == DONE))
            hold_d = wrap ? hold_q + 1'b1 : hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
    end
`else
    assign cnt_en = run;
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        case (state_q)
            FIB: begin
                if (stop_f_t)    state_d = IDLE;
                else if (f_done) state_d = DONE;
            end
            TIMER: begin
                if (stop_f_t)    state_d = IDLE;
                else if (t_done) state_d = DONE;
            end
            default: begin
                if (stop_f_t) begin
                    state_d = IDLE;
                end else if (start_f) begin
                    state_d  = FIB;
                    start_ok = 1'b1;
                end else if (start_t) begin
                    state_d  = TIMER;
                    start_ok = 1'b1;
                end else if (expire) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        en_f   = (state_q == FIB);
        en_t   = (state_q == TIMER);
        led    = {state_q == DONE, state_q == TIMER, state_q == FIB, prog_q};
        parity = ^prog_q;
    end

    // Any state change zeroes the prescaler; a wrap on a leaving edge is dropped.
    always_comb begin
        cnt_d = '0;
        if (cnt_en && (state_d == state_q))
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        tick_d = run && wrap && (state_d == state_q);
        clr_d  = start_ok;
        sel_d  = start_ok ? (state_d == TIMER) : sel_q;
        prog_d = ((state_q == IDLE) && update) ? prog : prog_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            clr_q  <= 1'b0;
            sel_q  <= 1'b0;
            prog_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            clr_q  <= clr_d;
            sel_q  <= sel_d;
            prog_q <= prog_d;
        end
    end

    assign tick = tick_q;
    assign clr  = clr_q;
    assign sel  = sel_q;

endmodule

// File: tb/tb_fib_timer_ctrl.sv
// Randomized bench for fib_timer_ctrl against a mode/age reference model.
// Define CTRL_AUTORETURN_EN to exercise the auto-return build.
module tb_fib_timer_ctrl;

    localparam int DIV  = 4;
    localparam int HOLD = 8;

    localparam int M_IDLE = 0;
    localparam int M_FIB  = 1;
    localparam int M_TMR  = 2;
    localparam int M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_f, start_t, stop_f_t, update;
    logic [2:0] prog;
    logic       f_done, t_done;
    logic [2:0] prog_q;
    logic       en_f, en_t, tick, clr, sel, parity;
    logic [5:0] led;

    int n_chk = 0;
    int n_err = 0;

    int m_mode, m_prog, m_sel, m_clr, m_age;

    fib_timer_ctrl #(.DIV(DIV), .HOLD_TICKS(HOLD)) dut (
        .clk(clk), .rst(rst),
        .start_f(start_f), .start_t(start_t),
        .stop_f_t(stop_f_t), .update(update), .prog(prog),
        .f_done(f_done), .t_done(t_done),
        .prog_q(prog_q), .en_f(en_f), .en_t(en_t),
        .tick(tick), .clr(clr), .sel(sel),
        .led(led), .parity(parity)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_prog = 0;
        m_sel  = 0;
        m_clr  = 0;
        m_age  = 0;
    endtask

    // One clock edge of the reference behaviour, from the current inputs.
    task automatic model_step();
        int nm;
        int nc;
        nm = m_mode;
        nc = 0;
        if (stop_f_t) nm = M_IDLE;
        else if (m_mode == M_FIB && f_done) nm = M_DONE;
        else if (m_mode == M_TMR && t_done) nm = M_DONE;
        else if ((m_mode == M_IDLE || m_mode == M_DONE) && start_f) begin
            nm = M_FIB; m_sel = 0; nc = 1;
        end else if ((m_mode == M_IDLE || m_mode == M_DONE) && start_t) begin
            nm = M_TMR; m_sel = 1; nc = 1;
        end
`ifdef CTRL_AUTORETURN_EN
        else if (m_mode == M_DONE && m_age + 1 == DIV * HOLD) nm = M_IDLE;
`endif
        if (m_mode == M_IDLE && update) m_prog = int'(prog);
        m_age  = (nm != m_mode || nc != 0) ? 0 : m_age + 1;
        m_mode = nm;
        m_clr  = nc;
    endtask

    task automatic check_outputs();
        logic       e_run, e_tick;
        logic [2:0] p;
        logic [5:0] e_led;
        p      = 3'(m_prog);
        e_run  = (m_mode == M_FIB) || (m_mode == M_TMR);
        e_tick = e_run && m_age > 0 && (m_age % DIV) == 0;
        e_led  = {m_mode == M_DONE, m_mode == M_TMR, m_mode == M_FIB, p};
        check("clr", clr, m_clr != 0);
        check("tick", tick, e_tick);
        check("en_f", en_f, m_mode == M_FIB);
        check("en_t", en_t, m_mode == M_TMR);
        check("sel", sel, m_sel != 0);
        check("prog_q", prog_q, p);
        check("parity", parity, ^p);
        check("led", led, e_led);
    endtask

    task automatic step(input logic sf, input logic st, input logic sp,
                        input logic up, input logic [2:0] pr,
                        input logic fd, input logic td);
        start_f  = sf;
        start_t  = st;
        stop_f_t = sp;
        update   = up;
        prog     = pr;
        f_done   = fd;
        t_done   = td;
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
        start_f  = 1'b0;
        start_t  = 1'b0;
        stop_f_t = 1'b0;
        update   = 1'b0;
        f_done   = 1'b0;
        t_done   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 3'd0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        start_f = 0; start_t = 0; stop_f_t = 0; update = 0;
        prog = 3'd0; f_done = 0; t_done = 0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        step(0, 0, 0, 1, 3'd3, 0, 0);
        check("prog3", prog_q, 3);
        check("led3", led, 6'b000011);
        check("par3", parity, 0);

        step(1, 0, 0, 0, 3'd0, 0, 0);
        check("clr_start", clr, 1);
        idle(10);
        step(0, 0, 0, 0, 3'd0, 1, 0);
        check("done_led", led[5], 1);
        idle(100);
`ifdef CTRL_AUTORETURN_EN
        check("autoret", led[5], 0);
`else
        check("held", led[5], 1);
`endif
        step(0, 0, 1, 0, 3'd0, 0, 0);
        check("sel_hold", sel, 0);

        step(0, 1, 0, 0, 3'd0, 0, 0);
        idle(40);
        step(0, 0, 1, 0, 3'd0, 0, 0);
        check("sel_t", sel, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 3'd0, 0, 1);

        step(1, 0, 0, 0, 3'd0, 0, 0);
        idle(3);
        step(0, 0, 1, 0, 3'd0, 1, 0);
        check("stop_win", led[5], 0);
        step(1, 0, 0, 0, 3'd0, 0, 0);
        step(0, 0, 0, 1, 3'd5, 0, 0);
        check("upd_run", prog_q, 3);
        step(0, 1, 0, 0, 3'd0, 0, 0);
        idle(5);

        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #1 rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                 3'($urandom), $urandom_range(0, 19) == 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
